// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared constants, state encoding and angle-wrap helper for
//               the cordic request queue.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int COORD_DEPTH_DEFAULT = $clog2(640);
    localparam int ANGLE_W             = 10;
    localparam int DEG_FULL            = 360;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } cordic_q_state_t;

    // Fold a negative signed angle into 0..359 when enabled; otherwise pass it through raw.
    function automatic logic [ANGLE_W-1:0] wrap_angle(input logic [ANGLE_W-1:0] a,
                                                      input logic               en);
        logic [ANGLE_W-1:0] r;
        r = a;
        if (en && a[ANGLE_W-1]) begin
            r = a + ANGLE_W'(DEG_FULL);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with wrap-bit pointers. Flags come from the
//               registered pointers only, so a write is never visible to the
//               read side in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Advance read/write pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
        end
    end

    // Storage array; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr[c_aw-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

endmodule
`default_nettype wire

// File: rtl/cordic_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : cordic_req_queue
// Description : Buffers tagged (x, y) requests, launches them one at a time on
//               the cordic engine, detects completion on a rising edge of
//               cordic_angle_rdy, and returns angle + tag on a valid/ready
//               port. A WAIT that outlives TIMEOUT_CYC cycles forces a
//               timeout result with angle 0.
//               Build option: define ANGLE_WRAP_EN to return angles as
//               unsigned 0..359 instead of the raw signed cordic angle.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_req_queue
    import cordic_pkg::*;
#(
    parameter int COORD_DEPTH = COORD_DEPTH_DEFAULT,
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [COORD_DEPTH-1:0] req_x,
    input  logic [COORD_DEPTH-1:0] req_y,
    input  logic [TAG_W-1:0]       req_tag,
    output logic [COORD_DEPTH-1:0] cordic_x,
    output logic [COORD_DEPTH-1:0] cordic_y,
    output logic                   cordic_start,
    input  logic [ANGLE_W-1:0]     cordic_angle,
    input  logic                   cordic_angle_rdy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ANGLE_W-1:0]     res_angle,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   res_timeout,
    output logic                   busy
);

    localparam int c_entry_w = 2*COORD_DEPTH + TAG_W;
    localparam int c_cnt_w   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
`ifdef ANGLE_WRAP_EN
    localparam logic c_wrap_en = 1'b1;
`else
    localparam logic c_wrap_en = 1'b0;
`endif

    cordic_q_state_t        r_state;
    cordic_q_state_t        w_state_nxt;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [c_entry_w-1:0]   w_fifo_rdata;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_done;
    logic                   w_timeout;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_rdy_prev;
    logic [COORD_DEPTH-1:0] r_op_x;
    logic [COORD_DEPTH-1:0] r_op_y;
    logic [TAG_W-1:0]       r_op_tag;
    logic                   r_res_valid;
    logic [ANGLE_W-1:0]     r_res_angle;
    logic [TAG_W-1:0]       r_res_tag;
    logic                   r_res_timeout;

    assign w_push    = req_valid && !w_fifo_full;
    assign req_ready = !w_fifo_full;

    sync_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata ({req_tag, req_y, req_x}),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, pop gating (never overwrite an unconsumed result), completion/timeout decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        cordic_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty && (!r_res_valid || res_ready)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                cordic_start = 1'b1;
                w_state_nxt  = WAIT;
            end
            WAIT: begin
                if (cordic_angle_rdy && !r_rdy_prev) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_cnt_w'(TIMEOUT_CYC - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand latch, WAIT timer, rdy history and the result holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_x        <= '0;
            r_op_y        <= '0;
            r_op_tag      <= '0;
            r_cnt         <= '0;
            r_rdy_prev    <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_angle   <= '0;
            r_res_tag     <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_rdy_prev <= cordic_angle_rdy;
            if (w_pop) {r_op_tag, r_op_y, r_op_x} <= w_fifo_rdata;
            if (r_state == LAUNCH)    r_cnt <= '0;
            else if (r_state == WAIT) r_cnt <= r_cnt + c_cnt_w'(1);
            if (w_done || w_timeout) begin
                r_res_valid   <= 1'b1;
                r_res_tag     <= r_op_tag;
                r_res_timeout <= w_timeout;
                r_res_angle   <= w_done ? wrap_angle(cordic_angle, c_wrap_en) : '0;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign cordic_x    = r_op_x;
    assign cordic_y    = r_op_y;
    assign res_valid   = r_res_valid;
    assign res_angle   = r_res_angle;
    assign res_tag     = r_res_tag;
    assign res_timeout = r_res_timeout;
    assign busy        = (r_state != IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_cordic_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_req_queue
// Description : Self-checking bench for cordic_req_queue with a behavioural
//               cordic engine model and randomized request traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_req_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready;
    logic [9:0] req_x, req_y;
    logic [3:0] req_tag;
    logic [9:0] cordic_x, cordic_y;
    logic       cordic_start;
    logic [9:0] cordic_angle;
    logic       cordic_angle_rdy;
    logic       res_valid, res_ready;
    logic [9:0] res_angle;
    logic [3:0] res_tag;
    logic       res_timeout, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // engine model controls / observations
    int         mdl_mode = 0;   // 0 pulse after latency, 1 never answer, 2 passive (test drives rdy)
    int         mdl_lat  = 8;
    bit         mdl_rand_lat = 1'b0;
    int         start_cnt = 0, start_cyc = -1, dbl_start = 0, stab_err = 0;
    logic [9:0] cap_x = '0, cap_y = '0;
    bit         watch = 1'b0, pend = 1'b0, prev_start = 1'b0;
    int         rcnt = 0;

    cordic_req_queue dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
        .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_start(cordic_start),
        .cordic_angle(cordic_angle), .cordic_angle_rdy(cordic_angle_rdy),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_angle(res_angle), .res_tag(res_tag), .res_timeout(res_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Angle the modelled engine produces for an operand pair.
    function automatic int model_angle(input logic [9:0] x, input logic [9:0] y);
        int sx, sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sx == 484 && sy == 129) return 15;
        if (sx == 6 && sy == -23)   return -75;
        return ((sx*7 + sy + 8192) % 361) - 180;
    endfunction

    // Expected res_angle for a given engine angle.
    function automatic logic [9:0] expect_angle(input int a);
        int r;
        r = a;
`ifdef ANGLE_WRAP_EN
        if (r < 0) r = r + 360;
`endif
        return 10'(r);
    endfunction

    // Cordic engine model, operating on the falling edge.
    initial begin
        cordic_angle     = '0;
        cordic_angle_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (mdl_mode != 2) cordic_angle_rdy = 1'b0;
            if (rst) begin
                pend = 1'b0; watch = 1'b0; prev_start = 1'b0;
            end else begin
                if (watch && !cordic_start && (cordic_x !== cap_x || cordic_y !== cap_y))
                    stab_err++;
                if (cordic_start) begin
                    if (prev_start) dbl_start++;
                    start_cnt++;
                    start_cyc = cyc;
                    cap_x = cordic_x;
                    cap_y = cordic_y;
                    watch = 1'b1;
                    pend  = (mdl_mode == 0);
                    rcnt  = mdl_rand_lat ? int'($urandom_range(1, 20)) : mdl_lat;
                end else if (pend) begin
                    rcnt--;
                    if (rcnt == 0) begin
                        cordic_angle     = 10'(model_angle(cap_x, cap_y));
                        cordic_angle_rdy = 1'b1;
                        pend = 1'b0;
                    end
                end
                prev_start = cordic_start;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int x, input int y, input int tag, input int budget,
                            output bit ok, output int acc_cyc);
        req_x = 10'(x); req_y = 10'(y); req_tag = 4'(tag);
        req_valid = 1'b1;
        ok = 1'b0; acc_cyc = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            if (req_ready) begin ok = 1'b1; acc_cyc = cyc; end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic get_result(input int budget, input bit rnd, output bit got,
                              output logic [9:0] ang, output logic [3:0] tag,
                              output logic tmo, output int vcyc);
        got = 1'b0; ang = '0; tag = '0; tmo = 1'b0; vcyc = -1;
        for (int i = 0; i < budget && !got; i++) begin
            res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (res_valid && res_ready) begin
                got = 1'b1; ang = res_angle; tag = res_tag; tmo = res_timeout; vcyc = cyc;
            end
            tick();
        end
        res_ready = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget);
        for (int i = 0; i < budget && start_cnt < target; i++) tick();
        checks++;
        if (start_cnt < target) begin
            errors++;
            $display("FAIL start_wait: starts=%0d required=%0d", start_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({res_valid, cordic_start, busy, req_ready, res_timeout} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_ctrl: valid/start/busy/ready/tmo=%b required=00010",
                     {res_valid, cordic_start, busy, req_ready, res_timeout});
        end
        checks++;
        if ({cordic_x, cordic_y, res_angle, res_tag} !== 34'd0) begin
            errors++;
            $display("FAIL reset_data: x=%0h y=%0h ang=%0h tag=%0h required all 0",
                     cordic_x, cordic_y, res_angle, res_tag);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok, got; int n, vc, sc, se;
        logic [9:0] a; logic [3:0] t; logic tm;
        mdl_mode = 0; mdl_lat = 16; sc = start_cnt; se = stab_err;
        push_req(484, 129, 3, 5, ok, n);
        get_result(60, 1'b0, got, a, t, tm, vc);
        checks++;
        if (start_cnt != sc + 1 || start_cyc != n + 2) begin
            errors++;
            $display("FAIL single_start: starts=%0d at cyc %0d required 1 at %0d",
                     start_cnt - sc, start_cyc, n + 2);
        end
        checks++;
        if (cap_x !== 10'd484 || cap_y !== 10'd129 || stab_err != se) begin
            errors++;
            $display("FAIL single_operands: x=%0d y=%0d unstable=%0d required 484 129 0",
                     cap_x, cap_y, stab_err - se);
        end
        checks++;
        if (!got || vc != start_cyc + 17) begin
            errors++;
            $display("FAIL single_latency: valid at cyc %0d required %0d", vc, start_cyc + 17);
        end
        checks++;
        if (a !== 10'd15 || t !== 4'd3 || tm !== 1'b0) begin
            errors++;
            $display("FAIL single_result: ang=%0d tag=%0d tmo=%0d required 15 3 0", a, t, tm);
        end
    endtask

    task automatic test_wrap();
        bit ok, got; int n, vc;
        logic [9:0] a, e; logic [3:0] t; logic tm;
`ifdef ANGLE_WRAP_EN
        e = 10'd285;
`else
        e = 10'h3B5;
`endif
        mdl_mode = 0; mdl_lat = 5;
        push_req(6, -23, 9, 5, ok, n);
        get_result(40, 1'b0, got, a, t, tm, vc);
        checks++;
        if (!got || a !== e || t !== 4'd9 || tm !== 1'b0) begin
            errors++;
            $display("FAIL wrap_result: got=%0d ang=%0h tag=%0d tmo=%0d required ang=%0h tag=9 tmo=0",
                     got, a, t, tm, e);
        end
    endtask

    task automatic test_full_order();
        bit ok, got, ok5; int n, vc, sc, acc;
        int xs[6], ys[6];
        logic [9:0] a; logic [3:0] t; logic tm;
        mdl_mode = 0; mdl_lat = 4; res_ready = 1'b0; sc = start_cnt; acc = 0;
        for (int k = 0; k < 6; k++) begin
            xs[k] = k*37 - 100;
            ys[k] = 50 - k*11;
        end
        for (int k = 0; k < 6; k++) begin
            push_req(xs[k], ys[k], k, 12, ok, n);
            if (ok) acc++;
        end
        checks++;
        if (acc != 5 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_accepts: accepted=%0d ready=%0b required 5 0", acc, req_ready);
        end
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (start_cnt != sc + 1 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: starts=%0d valid=%0b required 1 1", start_cnt - sc, res_valid);
        end
        ok5 = 1'b0;
        fork
            push_req(xs[5], ys[5], 5, 60, ok5, n);
            for (int k = 0; k < 6; k++) begin
                get_result(80, 1'b0, got, a, t, tm, vc);
                checks++;
                if (!got || t !== 4'(k) || a !== expect_angle(model_angle(10'(xs[k]), 10'(ys[k])))
                    || tm !== 1'b0) begin
                    errors++;
                    $display("FAIL order_result%0d: got=%0d tag=%0d ang=%0h required tag=%0d ang=%0h",
                             k, got, t, a, k, expect_angle(model_angle(10'(xs[k]), 10'(ys[k]))));
                end
            end
        join
        checks++;
        if (!ok5) begin
            errors++;
            $display("FAIL full_release: sixth accepted=%0d required 1", ok5);
        end
    endtask

    task automatic test_rdy_held();
        bit ok, got; int n, vc, sc, early;
        logic [9:0] a; logic [3:0] t; logic tm;
        mdl_mode = 2; sc = start_cnt; early = 0;
        push_req(100, 200, 7, 5, ok, n);
        push_req(-50, 30, 8, 5, ok, n);
        wait_starts(sc + 1, 10);
        tick(); tick(); tick();
        cordic_angle = 10'(-120); cordic_angle_rdy = 1'b1;
        get_result(20, 1'b0, got, a, t, tm, vc);
        checks++;
        if (!got || a !== expect_angle(-120) || t !== 4'd7) begin
            errors++;
            $display("FAIL held_first: got=%0d ang=%0h tag=%0d required ang=%0h tag=7",
                     got, a, t, expect_angle(-120));
        end
        wait_starts(sc + 2, 10);
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (res_valid) early++;
            tick();
        end
        res_ready = 1'b0;
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL held_no_level: early valid cycles=%0d required 0", early);
        end
        cordic_angle_rdy = 1'b0;
        tick();
        cordic_angle = 10'd45; cordic_angle_rdy = 1'b1;
        get_result(10, 1'b0, got, a, t, tm, vc);
        checks++;
        if (!got || a !== 10'd45 || t !== 4'd8 || tm !== 1'b0) begin
            errors++;
            $display("FAIL held_second: got=%0d ang=%0d tag=%0d tmo=%0d required 45 8 0", got, a, t, tm);
        end
        cordic_angle_rdy = 1'b0;
        mdl_mode = 0;
        tick();
    endtask

    task automatic test_timeout();
        bit ok, got; int n, n2, vc, sc;
        logic [9:0] a; logic [3:0] t; logic tm;
        mdl_mode = 1; sc = start_cnt;
        push_req(11, 22, 12, 5, ok, n);
        push_req(33, 44, 13, 5, ok, n2);
        get_result(100, 1'b0, got, a, t, tm, vc);
        checks++;
        if (!got || vc != n + 67) begin
            errors++;
            $display("FAIL timeout_len: valid at cyc %0d required %0d", vc, n + 67);
        end
        checks++;
        if (a !== 10'd0 || t !== 4'd12 || tm !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: ang=%0d tag=%0d tmo=%0d required 0 12 1", a, t, tm);
        end
        wait_starts(sc + 2, 10);
        checks++;
        if (start_cyc != vc + 1) begin
            errors++;
            $display("FAIL timeout_next_launch: start cyc %0d required %0d", start_cyc, vc + 1);
        end
        get_result(100, 1'b0, got, a, t, tm, vc);
        checks++;
        if (!got || a !== 10'd0 || t !== 4'd13 || tm !== 1'b1) begin
            errors++;
            $display("FAIL timeout_second: got=%0d ang=%0d tag=%0d tmo=%0d required 0 13 1",
                     got, a, t, tm);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int n, stale;
        mdl_mode = 1; stale = 0;
        push_req(5, 5, 1, 5, ok, n);
        push_req(6, 6, 2, 5, ok, n);
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({res_valid, cordic_start, req_ready, busy} !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_state: valid/start/ready/busy=%b required 0010",
                     {res_valid, cordic_start, req_ready, busy});
        end
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 90; i++) begin
            if (res_valid || cordic_start) stale++;
            tick();
        end
        res_ready = 1'b0;
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midreset_stale: stale activity cycles=%0d required 0", stale);
        end
    endtask

    task automatic test_random();
        localparam int NR = 25;
        int xs[NR], ys[NR], tg[NR];
        int acc;
        mdl_mode = 0; mdl_rand_lat = 1'b1; acc = 0;
        for (int i = 0; i < NR; i++) begin
            xs[i] = int'($urandom_range(0, 1023)) - 512;
            ys[i] = int'($urandom_range(0, 1023)) - 512;
            tg[i] = int'($urandom_range(0, 15));
        end
        fork
            for (int i = 0; i < NR; i++) begin
                bit ok; int n; int gap;
                gap = int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) tick();
                push_req(xs[i], ys[i], tg[i], 300, ok, n);
                if (ok) acc++;
            end
            for (int i = 0; i < NR; i++) begin
                bit got; int vc; logic [9:0] a, e; logic [3:0] t; logic tm;
                e = expect_angle(model_angle(10'(xs[i]), 10'(ys[i])));
                get_result(300, 1'b1, got, a, t, tm, vc);
                checks++;
                if (!got || a !== e || t !== 4'(tg[i]) || tm !== 1'b0) begin
                    errors++;
                    $display("FAIL random_result%0d: got=%0d ang=%0h tag=%0d tmo=%0d required ang=%0h tag=%0d tmo=0",
                             i, got, a, t, tm, e, tg[i]);
                end
            end
        join
        mdl_rand_lat = 1'b0;
        checks++;
        if (acc != NR || busy !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: accepted=%0d busy=%0b required %0d 0", acc, busy, NR);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0; req_tag = '0; res_ready = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_full_order();
        test_rdy_held();
        test_timeout();
        test_reset_mid();
        test_random();
        checks++;
        if (stab_err != 0 || dbl_start != 0) begin
            errors++;
            $display("FAIL operand_stability: unstable cycles=%0d double starts=%0d required 0 0",
                     stab_err, dbl_start);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
